// File: rtl/pipeline_hazard_ctrl.sv
// Depth/latency-generic hazard and forwarding controller for the in-order RISC-V pipeline.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl #(
  parameter int NUM_SLOTS = 3,
  parameter int REG_AW    = 5,
  parameter int LOAD_RDY  = 2,
  localparam int FWD_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_busy,
  input  logic              ex_branch_taken,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic [FWD_W-1:0]  fwd_a,
`ifdef HAZARD_PERF_CNT_EN
  output logic [FWD_W-1:0]  fwd_b,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`else
  output logic [FWD_W-1:0]  fwd_b
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  typedef enum logic [2:0] {
    MODE_ADVANCE,
    MODE_LUSE,
    MODE_FLUSH,
    MODE_BUSY,
    MODE_RESET
  } mode_t;

  slot_t             slots [NUM_SLOTS];
  slot_t             id_slot;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [FWD_W-1:0]  fwd_a_c;
  logic [FWD_W-1:0]  fwd_b_c;
  logic              luse;
  mode_t             mode;

  function automatic logic producer(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  assign id_slot = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  // Scan oldest to youngest so the youngest eligible producer is left standing.
  always_comb begin
    fwd_a_c = '0;
    fwd_b_c = '0;
    for (int k = NUM_SLOTS - 1; k >= 1; k--) begin
      if (!(slots[k].mem_read && (k < LOAD_RDY))) begin
        if (producer(slots[k], ex_rs1)) fwd_a_c = FWD_W'(k);
        if (producer(slots[k], ex_rs2)) fwd_b_c = FWD_W'(k);
      end
    end
    if (!slots[0].valid) begin
      fwd_a_c = '0;
      fwd_b_c = '0;
    end
  end

  always_comb begin
    luse = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if ((j < LOAD_RDY - 1) && slots[j].mem_read && id_valid &&
          ((id_use_rs1 && producer(slots[j], id_rs1)) ||
           (id_use_rs2 && producer(slots[j], id_rs2))))
        luse = 1'b1;
    end
  end

  always_comb begin
    mode = MODE_ADVANCE;
    if (reset)                mode = MODE_RESET;
    else if (ex_busy)         mode = MODE_BUSY;
    else if (ex_branch_taken) mode = MODE_FLUSH;
    else if (luse)            mode = MODE_LUSE;
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    fwd_a     = (mode == MODE_RESET) ? '0 : fwd_a_c;
    fwd_b     = (mode == MODE_RESET) ? '0 : fwd_b_c;
    case (mode)
      MODE_BUSY: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      MODE_FLUSH: begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      MODE_LUSE: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  // While EX is busy the op in slot0 stays put and a bubble opens behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
    end else if (mode == MODE_BUSY) begin
      slots[1] <= '0;
      for (int k = 2; k < NUM_SLOTS; k++) slots[k] <= slots[k-1];
    end else begin
      for (int k = 1; k < NUM_SLOTS; k++) slots[k] <= slots[k-1];
      if (mode == MODE_ADVANCE) begin
        slots[0] <= id_slot;
        ex_rs1   <= id_rs1;
        ex_rs2   <= id_rs2;
      end else begin
        slots[0] <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_id) stall_cycles <= stall_cycles + 32'd1;
      if (flush_id) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: default 3-slot instance plus a 4-slot, LOAD_RDY=3 instance.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       busy;
    logic       taken;
  } stim_t;

  logic  clk;
  logic  reset;
  stim_t st3, st4;

  logic       stall_if3, stall_id3, flush_id3, bubble_ex3;
  logic [1:0] fwd_a3, fwd_b3;
  logic       stall_if4, stall_id4, flush_id4, bubble_ex4;
  logic [1:0] fwd_a4, fwd_b4;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles3, flush_count3, stall_cycles4, flush_count4;
`endif

  logic [7:0] exp_q[$];
  bit         sel_q[$];
  string      tag_q[$];
  int         n_checks;
  int         n_pass;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut3 (
    .clk(clk), .reset(reset),
    .id_valid(st3.id_valid), .id_rs1(st3.rs1), .id_rs2(st3.rs2),
    .id_use_rs1(st3.u1), .id_use_rs2(st3.u2), .id_rd(st3.rd),
    .id_reg_write(st3.rw), .id_mem_read(st3.mr),
    .ex_busy(st3.busy), .ex_branch_taken(st3.taken),
    .stall_if(stall_if3), .stall_id(stall_id3), .flush_id(flush_id3),
    .bubble_ex(bubble_ex3), .fwd_a(fwd_a3),
`ifdef HAZARD_PERF_CNT_EN
    .fwd_b(fwd_b3), .stall_cycles(stall_cycles3), .flush_count(flush_count3)
`else
    .fwd_b(fwd_b3)
`endif
  );

  pipeline_hazard_ctrl #(.NUM_SLOTS(4), .REG_AW(5), .LOAD_RDY(3)) u_dut4 (
    .clk(clk), .reset(reset),
    .id_valid(st4.id_valid), .id_rs1(st4.rs1), .id_rs2(st4.rs2),
    .id_use_rs1(st4.u1), .id_use_rs2(st4.u2), .id_rd(st4.rd),
    .id_reg_write(st4.rw), .id_mem_read(st4.mr),
    .ex_busy(st4.busy), .ex_branch_taken(st4.taken),
    .stall_if(stall_if4), .stall_id(stall_id4), .flush_id(flush_id4),
    .bubble_ex(bubble_ex4), .fwd_a(fwd_a4),
`ifdef HAZARD_PERF_CNT_EN
    .fwd_b(fwd_b4), .stall_cycles(stall_cycles4), .flush_count(flush_count4)
`else
    .fwd_b(fwd_b4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ev(input logic si, input logic sd, input logic fl,
                                    input logic bx, input logic [1:0] fa, input logic [1:0] fb);
    return {si, sd, fl, bx, fa, fb};
  endfunction

  function automatic stim_t ins(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic rw,
                                input logic mr);
    stim_t s;
    s = '0;
    s.id_valid = 1'b1;
    s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.rd = rd; s.rw = rw; s.mr = mr;
    return s;
  endfunction

  // driver: apply one cycle of stimulus and queue the outputs expected in that cycle
  task automatic drive(input logic rst, input stim_t s, input bit sel4,
                       input logic [7:0] exp, input string tag);
    reset = rst;
    if (sel4) begin st4 = s; st3 = '0; end
    else      begin st3 = s; st4 = '0; end
    exp_q.push_back(exp);
    sel_q.push_back(sel4);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare on the falling edge, mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [7:0] e;
      bit         s;
      string      t;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      if (s) check_eq(t, {24'd0, stall_if4, stall_id4, flush_id4, bubble_ex4, fwd_a4, fwd_b4}, {24'd0, e});
      else   check_eq(t, {24'd0, stall_if3, stall_id3, flush_id3, bubble_ex3, fwd_a3, fwd_b3}, {24'd0, e});
    end
  end

  initial begin
    stim_t idle, r, k;
    n_checks = 0;
    n_pass   = 0;
    idle  = '0;
    reset = 1'b1;
    st3   = '0;
    st4   = '0;
    @(posedge clk);
    #1;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      r = stim_t'($urandom_range(0, 32'h7f_ffff));
      drive(1'b1, r, 1'b0, ev(0, 0, 0, 0, 0, 0), "reset_outs");
    end
    drive(1'b0, idle, 1'b0, ev(0, 0, 0, 0, 0, 0), "post_reset");

    // ALU -> ALU forward from EX/MEM
    drive(1'b0, ins(5'd1, 1, 5'd2, 1, 5'd5, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "fwd_prod");
    drive(1'b0, ins(5'd5, 1, 5'd3, 1, 5'd7, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "fwd_cons_id");
    drive(1'b0, idle, 1'b0, ev(0, 0, 0, 0, 2'd1, 0), "fwd_a_slot1");
    // two producers, each operand from a different slot
    drive(1'b0, ins(5'd0, 0, 5'd0, 0, 5'd9, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "p1");
    drive(1'b0, ins(5'd0, 0, 5'd0, 0, 5'd10, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "p2");
    drive(1'b0, ins(5'd9, 1, 5'd10, 1, 5'd11, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "dual_cons_id");
    drive(1'b0, idle, 1'b0, ev(0, 0, 0, 0, 2'd2, 2'd1), "fwd_dual");
    // youngest producer wins, rs2=x0 never forwards
    drive(1'b0, ins(5'd0, 0, 5'd0, 0, 5'd12, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "p3");
    drive(1'b0, ins(5'd0, 0, 5'd0, 0, 5'd12, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "p4");
    drive(1'b0, ins(5'd12, 1, 5'd0, 1, 5'd0, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "young_cons_id");
    drive(1'b0, idle, 1'b0, ev(0, 0, 0, 0, 2'd1, 0), "fwd_youngest");

    // load-use: one stall, then forward from MEM/WB
    drive(1'b0, ins(5'd2, 1, 5'd0, 0, 5'd6, 1, 1), 1'b0, ev(0, 0, 0, 0, 0, 0), "lw_x6");
    drive(1'b0, ins(5'd4, 1, 5'd6, 1, 5'd13, 1, 0), 1'b0, ev(1, 1, 0, 1, 0, 0), "luse_stall");
    drive(1'b0, ins(5'd4, 1, 5'd6, 1, 5'd13, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "luse_release");
    drive(1'b0, idle, 1'b0, ev(0, 0, 0, 0, 0, 2'd2), "fwd_b_load");

    // taken branch flushes a load in ID; a dependent next op must not stall
`ifdef HAZARD_PERF_CNT_EN
    check_eq("flush_cnt_pre", flush_count3, 32'd0);
`endif
    k = ins(5'd0, 0, 5'd0, 0, 5'd14, 1, 1);
    k.taken = 1'b1;
    drive(1'b0, k, 1'b0, ev(0, 0, 1, 1, 0, 0), "taken_flush");
`ifdef HAZARD_PERF_CNT_EN
    check_eq("flush_cnt_1", flush_count3, 32'd1);
    check_eq("stall_cnt_1", stall_cycles3, 32'd1);
`endif
    drive(1'b0, ins(5'd14, 1, 5'd0, 0, 5'd15, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "post_flush_no_luse");
    drive(1'b0, ins(5'd15, 1, 5'd0, 0, 5'd18, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "busy_setup");

    // multi-cycle EX holds slot0 and defers the taken branch
    k = ins(5'd18, 1, 5'd0, 0, 5'd19, 1, 0);
    k.busy  = 1'b1;
    k.taken = 1'b1;
    drive(1'b0, k, 1'b0, ev(1, 1, 0, 0, 2'd1, 0), "busy_1");
    drive(1'b0, k, 1'b0, ev(1, 1, 0, 0, 2'd2, 0), "busy_2");
    drive(1'b0, k, 1'b0, ev(1, 1, 0, 0, 0, 0), "busy_3");
    k.busy = 1'b0;
    drive(1'b0, k, 1'b0, ev(0, 0, 1, 1, 0, 0), "busy_then_taken");
`ifdef HAZARD_PERF_CNT_EN
    check_eq("flush_cnt_2", flush_count3, 32'd2);
    check_eq("stall_cnt_4", stall_cycles3, 32'd4);
`endif
    drive(1'b0, idle, 1'b0, ev(0, 0, 0, 0, 0, 0), "post_busy_idle");

    // reset in the middle of a load-use stall
    drive(1'b0, ins(5'd0, 0, 5'd0, 0, 5'd20, 1, 1), 1'b0, ev(0, 0, 0, 0, 0, 0), "lw_x20");
    drive(1'b0, ins(5'd20, 1, 5'd0, 0, 5'd21, 1, 0), 1'b0, ev(1, 1, 0, 1, 0, 0), "luse_pre_rst");
    drive(1'b1, ins(5'd20, 1, 5'd0, 0, 5'd21, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "rst_mid_stall");
    drive(1'b0, ins(5'd20, 1, 5'd0, 0, 5'd21, 1, 0), 1'b0, ev(0, 0, 0, 0, 0, 0), "post_rst_no_luse");
`ifdef HAZARD_PERF_CNT_EN
    check_eq("stall_cnt_rst", stall_cycles3, 32'd0);
`endif

    // deeper pipe: NUM_SLOTS=4, LOAD_RDY=3
    drive(1'b0, ins(5'd0, 0, 5'd0, 0, 5'd7, 1, 1), 1'b1, ev(0, 0, 0, 0, 0, 0), "d4_lw_x7");
    drive(1'b0, ins(5'd7, 1, 5'd0, 1, 5'd22, 1, 0), 1'b1, ev(1, 1, 0, 1, 0, 0), "d4_stall_1");
    drive(1'b0, ins(5'd7, 1, 5'd0, 1, 5'd22, 1, 0), 1'b1, ev(1, 1, 0, 1, 0, 0), "d4_stall_2");
    drive(1'b0, ins(5'd7, 1, 5'd0, 1, 5'd22, 1, 0), 1'b1, ev(0, 0, 0, 0, 0, 0), "d4_release");
    drive(1'b0, idle, 1'b1, ev(0, 0, 0, 0, 2'd3, 0), "d4_fwd_3");
    drive(1'b0, ins(5'd0, 0, 5'd0, 0, 5'd0, 1, 0), 1'b1, ev(0, 0, 0, 0, 0, 0), "d4_write_x0");
    drive(1'b0, ins(5'd0, 1, 5'd0, 1, 5'd23, 1, 0), 1'b1, ev(0, 0, 0, 0, 0, 0), "d4_x0_cons_id");
    drive(1'b0, idle, 1'b1, ev(0, 0, 0, 0, 0, 0), "d4_x0_no_fwd");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
